fir_output_stage: RTL and testbench



---
 rtl/fir_pkg.sv | 23 ++
 rtl/fir_out_fifo.sv | 66 ++++++
 rtl/fir_output_stage.sv | 157 +++++++++++++++
 tb/tb_fir_output_stage.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR output stage and the MAC chain that feeds it.
package fir_pkg;

  // Widths shared with the MAC tap instantiation.
  localparam int ACC_W_DEF = 24;
  localparam int OUT_W_DEF = 12;
  localparam int SHIFT_DEF = 11;

  // Dropped-result counter type and its saturation value.
  typedef logic [7:0] drop_cnt_t;
  localparam drop_cnt_t DROP_CNT_MAX = 8'hFF;

  // Largest representable signed sample of the given width.
  function automatic int sat_max(input int out_w);
    return (1 << (out_w - 1)) - 1;
  endfunction

  // Most negative representable signed sample of the given width.
  function automatic int sat_min(input int out_w);
    return -(1 << (out_w - 1));
  endfunction

endpackage

// File: rtl/fir_out_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// A write while full is accepted only if a read happens in the same cycle.
module fir_out_fifo import fir_pkg::*; #(
  parameter int W     = 12,
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         wr_en_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         rd_en_i,
  output logic [W-1:0] rd_data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_wr, do_rd;

  assign full_o    = (cnt_q == (AW + 1)'(DEPTH));
  assign empty_o   = (cnt_q == '0);
  assign do_rd     = rd_en_i && !empty_o;
  assign do_wr     = wr_en_i && (!full_o || do_rd);
  assign rd_data_o = mem_q[rd_ptr_q];

  // Next pointers and occupancy; pointers wrap naturally modulo DEPTH.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_wr, do_rd})
      2'b10:   cnt_d = cnt_q + (AW + 1)'(1);
      2'b01:   cnt_d = cnt_q - (AW + 1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and count registers.
  // NOTE: sequential state uses non-blocking assignments; reset is asynchronous.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array.
  // NOTE: storage is not reset; stale contents are unreachable while the count is zero.
  always_ff @(posedge clock) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/fir_output_stage.sv
// Terminal stage of the FIR chain: aligns valid with the last tap sum,
// rounds half-up, shifts, saturates, buffers results in a FWFT FIFO and
// keeps sticky saturation/overflow status plus a saturating drop counter.
module fir_output_stage import fir_pkg::*; #(
  parameter int ACC_W      = ACC_W_DEF,
  parameter int OUT_W      = OUT_W_DEF,
  parameter int SHIFT      = SHIFT_DEF,
  parameter int VALID_DLY  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [ACC_W-1:0] acc_in,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             clear_flags,
  output logic             sat_flag,
  output logic             ovf_flag,
  output drop_cnt_t        drop_cnt
);

  // One guard bit above the accumulator keeps the rounding add from wrapping.
  localparam int RW = ACC_W + 1;
  localparam logic signed [RW-1:0] RND_C  = RW'(1) << (SHIFT - 1);
  localparam logic signed [RW-1:0] SAT_HI = RW'(sat_max(OUT_W));
  localparam logic signed [RW-1:0] SAT_LO = RW'(sat_min(OUT_W));
  localparam logic [OUT_W-1:0]     OUT_HI = SAT_HI[OUT_W-1:0];
  localparam logic [OUT_W-1:0]     OUT_LO = SAT_LO[OUT_W-1:0];

  logic [VALID_DLY-1:0]  vdly_q;
  logic                  acc_qual;
  logic signed [RW-1:0]  rnd_q, rnd_d;
  logic                  r_vld_q;
  logic signed [RW-1:0]  shr;
  logic                  clamp;
  logic [OUT_W-1:0]      s_data_q, s_data_d;
  logic                  s_vld_q;
  logic                  fifo_full, fifo_empty;
  logic [OUT_W-1:0]      fifo_head;
  logic                  pop, drop;
  logic                  sat_q, sat_d;
  logic                  ovf_q, ovf_d;
  drop_cnt_t             drop_q, drop_d;

  // Valid delay line: in_valid reaches acc_qual when its sum reaches acc_in.
  generate
    if (VALID_DLY == 1) begin : g_dly1
      always_ff @(posedge clock or posedge reset) begin
        if (reset) vdly_q <= '0;
        else       vdly_q <= in_valid;
      end
    end else begin : g_dlyn
      always_ff @(posedge clock or posedge reset) begin
        if (reset) vdly_q <= '0;
        else       vdly_q <= {vdly_q[VALID_DLY-2:0], in_valid};
      end
    end
  endgenerate

  assign acc_qual = vdly_q[VALID_DLY-1];

  // Stage R: sign-extend and add half an output LSB (round half toward +inf).
  assign rnd_d = $signed({acc_in[ACC_W-1], acc_in}) + RND_C;

  // Stage R register; data only loads on a qualified sum.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rnd_q   <= '0;
      r_vld_q <= 1'b0;
    end else begin
      r_vld_q <= acc_qual;
      if (acc_qual) rnd_q <= rnd_d;
    end
  end

  // Stage S logic: drop fractional bits, clamp to the output range.
  always_comb begin
    shr      = rnd_q >>> SHIFT;
    clamp    = 1'b0;
    s_data_d = shr[OUT_W-1:0];
    if (shr > SAT_HI) begin
      s_data_d = OUT_HI;
      clamp    = 1'b1;
    end else if (shr < SAT_LO) begin
      s_data_d = OUT_LO;
      clamp    = 1'b1;
    end
  end

  // Stage S register; its valid drives the FIFO write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s_data_q <= '0;
      s_vld_q  <= 1'b0;
    end else begin
      s_vld_q <= r_vld_q;
      if (r_vld_q) s_data_q <= s_data_d;
    end
  end

  fir_out_fifo #(
    .W     (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .wr_en_i   (s_vld_q),
    .wr_data_i (s_data_q),
    .rd_en_i   (pop),
    .rd_data_o (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_empty ? '0 : fifo_head;
  assign pop       = out_valid && out_ready;
  // A full FIFO only loses the result when nothing leaves in the same cycle.
  assign drop      = s_vld_q && fifo_full && !pop;

  // Sticky status next-state; a coincident set event overrides clear_flags.
  always_comb begin
    sat_d  = sat_q;
    ovf_d  = ovf_q;
    drop_d = drop_q;
    if (clear_flags) begin
      sat_d  = 1'b0;
      ovf_d  = 1'b0;
      drop_d = '0;
    end
    if (r_vld_q && clamp) sat_d = 1'b1;
    if (drop) begin
      ovf_d = 1'b1;
      if (drop_d != DROP_CNT_MAX) drop_d = drop_d + drop_cnt_t'(1);
    end
  end

  // Sticky status registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sat_q  <= 1'b0;
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      sat_q  <= sat_d;
      ovf_q  <= ovf_d;
      drop_q <= drop_d;
    end
  end

  assign sat_flag = sat_q;
  assign ovf_flag = ovf_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_fir_output_stage.sv
// Scoreboard bench for fir_output_stage: a reference model built from
// input history and plain arithmetic predicts FIFO contents and status;
// a negedge monitor compares every presented output against it.
module tb_fir_output_stage;

  localparam int ACC_W   = 24;
  localparam int OUT_W   = 12;
  localparam int SHIFT   = 11;
  localparam int D       = 16;
  localparam int DEPTH   = 4;
  localparam int OUT_MAX = 2047;
  localparam int OUT_MIN = -2048;

  logic             clock;
  logic             reset;
  logic             in_valid;
  logic [ACC_W-1:0] acc_in;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             clear_flags;
  logic             sat_flag;
  logic             ovf_flag;
  logic [7:0]       drop_cnt;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int acc_at[int];
  bit vin_h[$];
  int acc_h[$];
  int exp_q[$];
  int seen_q[$];
  int m_occ    = 0;
  bit exp_sat  = 0;
  bit exp_ovf  = 0;
  int exp_cnt  = 0;

  int ra_in[6]  = '{1023, 1024, 3071, 3072, -1024, -1025};
  int ra_out[6] = '{0, 1, 1, 2, 0, -1};
  int bb[20];

  fir_output_stage #(
    .ACC_W      (ACC_W),
    .OUT_W      (OUT_W),
    .SHIFT      (SHIFT),
    .VALID_DLY  (D),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .acc_in      (acc_in),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .clear_flags (clear_flags),
    .sat_flag    (sat_flag),
    .ovf_flag    (ovf_flag),
    .drop_cnt    (drop_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Output sample = floor((acc + 2^(SHIFT-1)) / 2^SHIFT), clamped to OUT_W.
  function automatic int ref_sample(input int acc, output bit clamped);
    longint den = longint'(1) << SHIFT;
    longint num = longint'(acc) + den / 2;
    longint q;
    if (num >= 0) q = num / den;
    else          q = -((-num + den - 1) / den);
    clamped = 1'b0;
    if (q > OUT_MAX) begin
      q = OUT_MAX;
      clamped = 1'b1;
    end else if (q < OUT_MIN) begin
      q = OUT_MIN;
      clamped = 1'b1;
    end
    return int'(q);
  endfunction

  // Reference model: a sample flagged at cycle c uses acc_in of cycle c+D,
  // clamps are reported one edge before the result lands in the FIFO, and
  // the result lands D+3 edges after the flag.
  initial forever begin : model
    bit pop, sat_ev, wr_ev, drop, c;
    int wv, sv, n;
    @(posedge clock or posedge reset);
    if (reset) begin
      vin_h.delete();
      acc_h.delete();
      exp_q.delete();
      m_occ   = 0;
      exp_sat = 0;
      exp_ovf = 0;
      exp_cnt = 0;
    end else begin
      vin_h.push_back(in_valid);
      acc_h.push_back(int'($signed(acc_in)));
      if (vin_h.size() > D + 3) begin
        vin_h.pop_front();
        acc_h.pop_front();
      end
      n      = vin_h.size();
      pop    = (m_occ > 0) && out_ready;
      sat_ev = 1'b0;
      wr_ev  = 1'b0;
      wv     = 0;
      if (n >= D + 2 && vin_h[n-(D+2)]) begin
        sv     = ref_sample(acc_h[n-2], c);
        sat_ev = c;
      end
      if (n >= D + 3 && vin_h[n-(D+3)]) begin
        wv    = ref_sample(acc_h[n-3], c);
        wr_ev = 1'b1;
      end
      drop = wr_ev && (m_occ == DEPTH) && !pop;
      if (pop) m_occ--;
      if (wr_ev && !drop) begin
        m_occ++;
        exp_q.push_back(wv);
      end
      if (clear_flags) begin
        exp_sat = 0;
        exp_ovf = 0;
        exp_cnt = 0;
      end
      if (sat_ev) exp_sat = 1;
      if (drop) begin
        exp_ovf = 1;
        if (exp_cnt < 255) exp_cnt++;
      end
    end
  end

  // Monitor: compares the presented head and status against the model.
  initial forever begin : monitor
    @(negedge clock);
    if (!reset) begin
      check("out_valid", out_valid, exp_q.size() > 0);
      if (out_valid === 1'b1 && exp_q.size() > 0) begin
        check("out_data", $signed(out_data), exp_q[0]);
        if (out_ready) begin
          void'(exp_q.pop_front());
          seen_q.push_back(int'($signed(out_data)));
        end
      end
      check("sat_flag", sat_flag, exp_sat);
      check("ovf_flag", ovf_flag, exp_ovf);
      check("drop_cnt", drop_cnt, exp_cnt);
    end
  end

  // One cycle of stimulus; a flagged sample schedules its sum D cycles later.
  task automatic drive(input bit v, input int val, input bit rdy, input bit clr);
    @(posedge clock);
    #1;
    cyc++;
    in_valid = v;
    if (v) acc_at[cyc + D] = val;
    if (acc_at.exists(cyc)) begin
      acc_in = ACC_W'(acc_at[cyc]);
      acc_at.delete(cyc);
    end else begin
      acc_in = ACC_W'($urandom);
    end
    out_ready   = rdy;
    clear_flags = clr;
  endtask

  task automatic idle(input int n, input bit rdy);
    repeat (n) drive(1'b0, 0, rdy, 1'b0);
  endtask

  task automatic check_seen(input string name, input int idx, input int req);
    logic signed [31:0] act;
    act = 'x;
    if (idx < seen_q.size()) act = seen_q[idx];
    check(name, act, req);
  endtask

  initial begin : stimulus
    int c0, first, data, stale;
    reset       = 1'b1;
    in_valid    = 1'b0;
    acc_in      = '0;
    out_ready   = 1'b0;
    clear_flags = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_sat_flag", sat_flag, 0);
    check("rst_ovf_flag", ovf_flag, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    @(posedge clock);
    #1 reset = 1'b0;

    // Rounding at the default Q-format.
    seen_q.delete();
    for (int i = 0; i < 6; i++) drive(1'b1, ra_in[i], 1'b1, 1'b0);
    idle(D + 6, 1'b1);
    check("round_count", seen_q.size(), 6);
    for (int i = 0; i < 6; i++) check_seen("round_value", i, ra_out[i]);
    check("round_no_sat", sat_flag, 0);

    // Saturation at both rails, then clear.
    seen_q.delete();
    drive(1'b1, 32'h007F_FFFF, 1'b1, 1'b0);
    drive(1'b1, -8388608, 1'b1, 1'b0);
    idle(D + 6, 1'b1);
    check_seen("sat_hi", 0, 2047);
    check_seen("sat_lo", 1, -2048);
    check("sat_flag_set", sat_flag, 1);
    drive(1'b0, 0, 1'b1, 1'b1);
    @(negedge clock);
    check("sat_flag_before_edge", sat_flag, 1);
    idle(1, 1'b1);
    @(negedge clock);
    check("sat_flag_cleared", sat_flag, 0);

    // Alignment and latency with garbage on acc_in outside the sample cycle.
    drive(1'b1, 4096, 1'b1, 1'b0);
    c0    = cyc;
    first = -1;
    data  = -99999;
    for (int i = 0; i < 40; i++) begin
      drive(1'b0, 0, 1'b1, 1'b0);
      @(negedge clock);
      if (out_valid === 1'b1 && first < 0) begin
        first = cyc;
        data  = int'($signed(out_data));
      end
    end
    check("latency_cycles", first - c0, 19);
    check("latency_data", data, 2);

    // Backpressure: six results into a four-entry FIFO.
    drive(1'b0, 0, 1'b1, 1'b1);
    seen_q.delete();
    for (int k = 1; k <= 6; k++) drive(1'b1, k * 2048, 1'b0, 1'b0);
    idle(D + 6, 1'b0);
    @(negedge clock);
    check("bp_out_valid", out_valid, 1);
    check("bp_ovf_flag", ovf_flag, 1);
    check("bp_drop_cnt", drop_cnt, 2);
    idle(8, 1'b1);
    @(negedge clock);
    check("bp_drained", out_valid, 0);
    check("bp_count", seen_q.size(), 4);
    for (int i = 0; i < 4; i++) check_seen("bp_order", i, i + 1);

    // Full FIFO with a pop in the same cycle as a new write.
    drive(1'b0, 0, 1'b1, 1'b1);
    seen_q.delete();
    for (int k = 10; k <= 13; k++) drive(1'b1, k * 2048, 1'b0, 1'b0);
    idle(D + 6, 1'b0);
    @(negedge clock);
    check("fp_full", out_valid, 1);
    for (int i = 0; i < D + 6; i++) drive(i == 0, 14 * 2048, i == D + 2, 1'b0);
    @(negedge clock);
    check("fp_drop_cnt", drop_cnt, 0);
    check("fp_ovf_flag", ovf_flag, 0);
    idle(8, 1'b1);
    check("fp_count", seen_q.size(), 5);
    for (int i = 0; i < 5; i++) check_seen("fp_order", i, 10 + i);

    // Back-to-back stream with the consumer always ready.
    drive(1'b0, 0, 1'b1, 1'b1);
    seen_q.delete();
    for (int i = 0; i < 20; i++) begin
      bb[i] = int'($urandom_range(0, 200)) - 100;
      drive(1'b1, bb[i] * 2048, 1'b1, 1'b0);
    end
    idle(D + 6, 1'b1);
    check("b2b_count", seen_q.size(), 20);
    for (int i = 0; i < 20; i++) check_seen("b2b_value", i, bb[i]);
    check("b2b_drop_cnt", drop_cnt, 0);

    // Randomized traffic, backpressure and flag clears.
    for (int i = 0; i < 400; i++) begin
      int v;
      v = int'($signed(ACC_W'($urandom))) >>> $urandom_range(0, 3);
      drive(1'($urandom_range(0, 1)), v, $urandom_range(0, 9) < 7,
            $urandom_range(0, 49) == 0);
    end
    idle(D + 10, 1'b1);
    @(negedge clock);
    check("rand_drained", out_valid, 0);

    // Asynchronous reset between edges with results queued.
    drive(1'b0, 0, 1'b1, 1'b1);
    drive(1'b1, 32'h007F_FFFF, 1'b0, 1'b0);
    drive(1'b1, 32'h007F_FFFF, 1'b0, 1'b0);
    idle(D + 6, 1'b0);
    @(negedge clock);
    check("ar_pre_valid", out_valid, 1);
    check("ar_pre_sat", sat_flag, 1);
    #2 reset = 1'b1;
    #1;
    check("ar_out_valid", out_valid, 0);
    check("ar_out_data", out_data, 0);
    check("ar_sat_flag", sat_flag, 0);
    check("ar_ovf_flag", ovf_flag, 0);
    check("ar_drop_cnt", drop_cnt, 0);
    @(posedge clock);
    #1 reset = 1'b0;
    stale = 0;
    for (int i = 0; i < 30; i++) begin
      drive(1'b0, 0, 1'b1, 1'b0);
      @(negedge clock);
      if (out_valid !== 1'b0) stale++;
    end
    check("ar_no_stale", stale, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
